// File: rtl/win_detect.sv
// win_detect: connect-four line and full-board checker for a 6x7 board.
// Optional draw detection is built when WIN_DETECT_DRAW_EN is defined.
module win_detect #(
   parameter int RUN_LEN = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [83:0] board,
   input  logic [6:0]  location,
   output logic        term,
   output logic [1:0]  winner,
   output logic        draw,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t            state;
   logic [83:0]       shadow;
   logic [1:0]        colour;
   logic [1:0]        dir;
   logic              side;
   logic [2:0]        step;
   logic [2:0]        run;
   logic              win;
   logic signed [3:0] r0, c0, cr, cc;

   logic              org_hit;
   logic [2:0]        org_r, org_c;
   logic [1:0]        org_cell;
   logic              org_ok;
   logic              on_board;
   logic              match;
   logic signed [3:0] dr, dc, sdr, sdc, ndr, ndc;
   logic [3:0]        run_inc;
   logic              last_step;
   logic              full;

   function automatic logic [1:0] cell_at(
      input logic [83:0] b,
      input logic [2:0]  r,
      input logic [2:0]  c
   );
      logic [6:0] lo;
      lo = 7'd14 * {4'd0, r} + 7'd12 - {3'd0, c, 1'b0};
      return 2'(b >> lo);
   endfunction

   function automatic logic signed [3:0] dir_dr(input logic [1:0] d);
      return (d == 2'd0) ? 4'sd0 : 4'sd1;
   endfunction

   function automatic logic signed [3:0] dir_dc(input logic [1:0] d);
      logic signed [3:0] v;
      v = 4'sd0;
      unique case (d)
         2'd0: v = 4'sd1;
         2'd1: v = 4'sd0;
         2'd2: v = 4'sd1;
         2'd3: v = -4'sd1;
         default: v = 4'sd0;
      endcase
      return v;
   endfunction

   // Map the drop location back to (row, col) and fetch its piece.
   always_comb begin
      org_hit = 1'b0;
      org_r   = '0;
      org_c   = '0;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++)
            if (location == 7'(13 + 14 * r - 2 * c)) begin
               org_hit = 1'b1;
               org_r   = 3'(r);
               org_c   = 3'(c);
            end
      org_cell = cell_at(board, org_r, org_c);
      org_ok   = org_hit && (org_cell == 2'b01 || org_cell == 2'b10);
   end

   // Current probe: direction vectors, bounds test and colour match.
   always_comb begin
      dr        = dir_dr(dir);
      dc        = dir_dc(dir);
      ndr       = dir_dr(dir + 2'd1);
      ndc       = dir_dc(dir + 2'd1);
      sdr       = side ? -dr : dr;
      sdc       = side ? -dc : dc;
      on_board  = (cr >= 4'sd0) && (cr <= 4'sd5) &&
                  (cc >= 4'sd0) && (cc <= 4'sd6);
      match     = on_board &&
                  (cell_at(shadow, cr[2:0], cc[2:0]) == colour);
      run_inc   = {1'b0, run} + 4'd1;
      last_step = (step == 3'(RUN_LEN - 2));
   end

`ifdef WIN_DETECT_DRAW_EN
   // A board counts as full once no cell holds the empty code.
   always_comb begin
      full = 1'b1;
      for (int i = 0; i < 42; i++)
         if (shadow[2*i +: 2] == 2'b00)
            full = 1'b0;
   end
`else
   assign full = 1'b0;
`endif

   // Scan FSM: latch on board change, walk each direction, report.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         shadow <= '0;
         colour <= '0;
         dir    <= '0;
         side   <= 1'b0;
         step   <= '0;
         run    <= 3'd1;
         win    <= 1'b0;
         r0     <= '0;
         c0     <= '0;
         cr     <= '0;
         cc     <= '0;
         term   <= 1'b0;
         winner <= 2'b00;
         draw   <= 1'b0;
         busy   <= 1'b0;
      end else if (board != shadow) begin
         shadow <= board;
         colour <= org_cell;
         r0     <= $signed({1'b0, org_r});
         c0     <= $signed({1'b0, org_c});
         cr     <= $signed({1'b0, org_r});
         cc     <= $signed({1'b0, org_c}) + 4'sd1;
         dir    <= 2'd0;
         side   <= 1'b0;
         step   <= '0;
         run    <= 3'd1;
         win    <= 1'b0;
         busy   <= 1'b1;
         state  <= org_ok ? SCAN : DONE;
      end else begin
         unique case (state)
            IDLE: ;
            SCAN: begin
               if (match && run_inc >= 4'(RUN_LEN)) begin
                  win   <= 1'b1;
                  state <= DONE;
               end else if (match && !last_step) begin
                  run  <= run_inc[2:0];
                  step <= step + 3'd1;
                  cr   <= cr + sdr;
                  cc   <= cc + sdc;
               end else if (!side) begin
                  if (match)
                     run <= run_inc[2:0];
                  side <= 1'b1;
                  step <= '0;
                  cr   <= r0 - dr;
                  cc   <= c0 - dc;
               end else if (dir == 2'd3) begin
                  state <= DONE;
               end else begin
                  dir  <= dir + 2'd1;
                  side <= 1'b0;
                  step <= '0;
                  run  <= 3'd1;
                  cr   <= r0 + ndr;
                  cc   <= c0 + ndc;
               end
            end
            DONE: begin
               term   <= win | full;
               winner <= win ? colour : 2'b00;
               draw   <= !win && full;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_win_detect.sv
// tb_win_detect: directed vectors for win_detect (RUN_LEN = 4).
// Expected latencies and results are worked out by hand per board.
module tb_win_detect;

   logic        clk = 1'b0;
   logic        rst;
   logic [83:0] board;
   logic [6:0]  location;
   logic        term;
   logic [1:0]  winner;
   logic        draw;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   logic [83:0] b_vert, b_vert_u, b_horz, b_horz_u;
   logic [83:0] b_anti, b_three, b_full;
   int          cyc, cyc2;

   win_detect #(.RUN_LEN(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .board    (board),
      .location (location),
      .term     (term),
      .winner   (winner),
      .draw     (draw),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   function automatic logic [83:0] put(
      input logic [83:0] b, input int r, input int c, input logic [1:0] v
   );
      b[13 + 14 * r - 2 * c -: 2] = v;
      return b;
   endfunction

   function automatic logic [6:0] loc(input int r, input int c);
      return 7'(13 + 14 * r - 2 * c);
   endfunction

   task automatic wait_idle(output int n);
      n = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (!busy)
            break;
         n++;
      end
      if (busy)
         check("scan_timeout", int'(busy), 0);
   endtask

   task automatic outs(input string tag, input int t, input int w, input int d);
      check({tag, "_term"}, int'(term), t);
      check({tag, "_winner"}, int'(winner), w);
      check({tag, "_draw"}, int'(draw), d);
   endtask

   initial begin
      rst      = 1'b1;
      board    = '0;
      location = 7'd1;

      b_vert = '0;
      for (int r = 0; r < 4; r++)
         b_vert = put(b_vert, r, 6, 2'b01);
      b_vert_u = put(b_vert, 3, 6, 2'b00);
      b_horz = '0;
      for (int c = 0; c < 4; c++)
         b_horz = put(b_horz, 0, c, 2'b01);
      b_horz_u = put(b_horz, 0, 3, 2'b00);
      b_anti = '0;
      for (int k = 0; k < 4; k++)
         b_anti = put(b_anti, k, 3 - k, 2'b10);
      b_three = put(b_anti, 3, 0, 2'b00);
      b_full = '0;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++)
            b_full = put(b_full, r, c,
                         (((r / 2) + c) % 2 == 0) ? 2'b01 : 2'b10);

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      outs("reset", 0, 0, 0);
      check("reset_busy", int'(busy), 0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("idle_busy", int'(busy), 0);
      check("idle_term", int'(term), 0);

      board = b_vert; location = 7'd85;
      wait_idle(cyc);
      check("loc_hi_busy", cyc, 1);
      outs("loc_hi", 0, 0, 0);

      board = b_horz; location = 7'd8;
      wait_idle(cyc);
      check("loc_even_busy", cyc, 1);
      outs("loc_even", 0, 0, 0);

      board = b_vert; location = loc(3, 6);
      wait_idle(cyc);
      check("vert_busy", cyc, 7);
      outs("vert", 1, 1, 0);

      board = b_vert_u; location = loc(3, 6);
      wait_idle(cyc);
      check("vert_undo_busy", cyc, 1);
      outs("vert_undo", 0, 0, 0);

      board = b_horz; location = loc(0, 3);
      wait_idle(cyc);
      check("horz_busy", cyc, 5);
      outs("horz", 1, 1, 0);

      board = b_horz_u; location = loc(0, 3);
      wait_idle(cyc);
      outs("horz_undo", 0, 0, 0);

      board = b_anti; location = loc(0, 3);
      wait_idle(cyc);
      check("anti_busy", cyc, 10);
      outs("anti", 1, 2, 0);

      board = b_three; location = loc(0, 3);
      wait_idle(cyc);
      check("three_busy", cyc, 11);
      outs("three", 0, 0, 0);

      board = b_full; location = loc(5, 6);
      wait_idle(cyc);
      check("full_bound", int'(cyc <= 25), 1);
`ifdef WIN_DETECT_DRAW_EN
      outs("full", 1, 0, 1);
`else
      outs("full", 0, 0, 0);
`endif

      board = '0; location = loc(0, 0);
      wait_idle(cyc);
      check("clear_busy", cyc, 1);
      outs("clear", 0, 0, 0);

      board = b_anti; location = loc(0, 3);
      cyc = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (busy)
            cyc++;
      end
      check("abort_hold_term", int'(term), 0);
      board = b_three;
      wait_idle(cyc2);
      check("abort_busy", cyc + cyc2, 14);
      outs("abort", 0, 0, 0);

      board = b_anti;
      wait_idle(cyc);
      outs("anti2", 1, 2, 0);

      board = b_horz;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("mid_busy", int'(busy), 1);
      check("mid_hold_winner", int'(winner), 2);
      rst   = 1'b1;
      board = '0;
      @(posedge clk);
      @(negedge clk);
      outs("rst_mid", 0, 0, 0);
      check("rst_mid_busy", int'(busy), 0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_term", int'(term), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/win_detect.md
# win_detect

Connect-four result checker sitting directly downstream of the column-select/drop controller. It watches the 6x7 board and the location of the most recent drop and walks outward from that cell in the four line directions, one cell per cycle, looking for four in a row. It also flags a full board as a draw. Its `term` output feeds back to the controller to block further drops.

## Interface
Parameters:
- `RUN_LEN`, 4: pieces in a line needed to win; legal range 2..7.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset: synchronous, active-high; clock `clk`.
- `board`  in  84  play field. Cell (row r 0..5 from bottom, col c 0..6 from left) is `board[13+14r-2c -: 2]`. Cell codes: 00 = empty, 01 = player 1, 10 = player 2, 11 = illegal, treated as empty.
- `location`  in  7  high-bit index of the last written cell, encoded as 13+14r-2c.
- `term`  out  1  game over, either a win or a draw.
- `winner`  out  2  01 or 10 when there is a win, 00 otherwise.
- `draw`  out  1  board full with no win.
- `busy`  out  1  a scan is in progress.

## Operation
- `shadow` register holds the last accepted board.
  - A scan is triggered on any cycle where `board != shadow`.
- FSM states: IDLE, SCAN, DONE.
- IDLE: when a scan is triggered:
  - latch `board` into `shadow`;
  - decode the origin: r = location/14, c = (13 - location%14)/2;
  - latch colour = origin cell;
  - go to SCAN.
- Invalid origin goes straight to DONE with no win. Invalid means any of:
  - `location` even;
  - `location` > 83;
  - origin cell empty or 11.
- SCAN: directions are processed in the fixed order horizontal (0,+1), vertical (+1,0), diagonal (+1,+1), anti-diagonal (+1,-1).
  - For each direction, walk the positive side, then the negative side, probing one cell per cycle.
  - A side stops at the first probe that is off-board or does not match colour, or after RUN_LEN-1 steps. The stopping probe still costs its cycle.
  - The run counter starts at 1 for the origin and increments on each match.
  - When run ≥ RUN_LEN: early exit to DONE with a win. No further directions are probed.
  - Before each new direction, run resets to 1.
- DONE (one cycle):
  - Register the results: `term`, `winner` = colour on a win, and `draw`.
  - `draw` = 1 iff there is no win and all 42 cells are non-zero. This is evaluated combinationally on `shadow`.
  - Return to IDLE.
- Board change during SCAN or DONE: abort, re-latch, and restart from the first direction next cycle. The outputs keep their old values.
- `term`, `winner` and `draw` hold their previous values until DONE overwrites them. An undo or a game restart therefore clears them only after its own scan completes.
- Coordinates are 4-bit signed internally. Off-board means r∉0..5 or c∉0..6.

## Timing
- Reset values: `term`=0, `winner`=00, `draw`=0, `busy`=0, `shadow`=0, state IDLE.
- Trigger on cycle N:
  - SCAN begins at edge N+1, and `busy`=1 from N+1.
  - Each probe takes 1 cycle.
  - Results are visible the cycle after the DONE edge, and `busy` drops at the same edge.
- Worst-case latency with RUN_LEN=4 is 1 + 24 probes + 1 = 26 cycles. A horizontal win found on the 3rd positive probe takes 1 + 3 + 1 = 5 cycles.
- `rst` overrides everything, including mid-scan. No result is reported for an interrupted scan.

## Configuration
- `WIN_DETECT_DRAW_EN`
  - Defined: the full-board check is built and `draw`/`term` assert on a full board with no win.
  - Undefined: the check logic is omitted, `draw` is tied to 0, and a full board without a win leaves `term`=0.

## Test plan
- Reset, then board=0 with location=1 → no scan triggered; all outputs 0 and `busy`=0.
- Player-1 pieces at row 0, cols 0..3, last drop location=7 (c=3) → `busy` for 5 cycles, then `term`=1, `winner`=01.
- Player-2 anti-diagonal (0,3)(1,2)(2,1)(3,0) with last drop at (0,3) (location=7) → `term`=1, `winner`=10 after ≤26 cycles; no win reported for three-in-a-row variants.
- After the win, clear location 7 (undo) → rescan → `term`=0, `winner`=00.
- Full board with no line (alternating pattern) → with `WIN_DETECT_DRAW_EN`: `term`=1, `draw`=1, `winner`=00; without it: all 0.
- Board changes during SCAN, or `rst` asserted mid-scan → scan restarts, or all outputs reset the next cycle; no stale result is reported.
